// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: multi-cycle binary-to-BCD converter (shift-and-add-3).
// One add3 corrector per BCD digit is reused on every iteration; the
// conversion is sequenced by a small FSM with a start/busy/done handshake.
//
// Build option:
//   BIN2BCD_FAST_EN defined   -> correction and shift happen in the same
//                                cycle (WIDTH+1 cycle latency, longer path).
//   BIN2BCD_FAST_EN undefined -> correction is registered in its own ADJUST
//                                cycle (2*WIDTH+1 cycle latency).

// Single-digit double-dabble correction: digits of 5 or more get +3.
module bin2bcd_add3 (
  input  logic [3:0] digit,
  output logic [3:0] corrected
);

  // Digits 5..9 are biased by 3 so the following left shift carries into
  // the next decade; 0..4 pass through untouched.
  always_comb begin
    corrected = digit;
    case (digit)
      4'd5, 4'd6, 4'd7, 4'd8, 4'd9: corrected = digit + 4'd3;
      default:                       corrected = digit;
    endcase
  end

endmodule

module bin2bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADJUST = 2'd1,
    SHIFT  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [WIDTH-1:0]  bin_sr;
  logic [BW-1:0]     bcd_sr;
  logic [CW-1:0]     cnt;
  logic [BW-1:0]     bcd_adj;
  logic [BW+WIDTH-1:0] shifted;

  // One corrector per digit, all looking at the current BCD shift register.
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bin2bcd_add3 u_add3 (
      .digit     (bcd_sr[4*g +: 4]),
      .corrected (bcd_adj[4*g +: 4])
    );
  end

  // Combined shift of the BCD and binary registers; the fast build shifts
  // the already-corrected digits so one cycle does a whole iteration.
  always_comb begin
`ifdef BIN2BCD_FAST_EN
    shifted = {bcd_adj, bin_sr} << 1;
`else
    shifted = {bcd_sr, bin_sr} << 1;
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic: IDLE -> (ADJUST -> SHIFT)* -> DONE -> IDLE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) begin
`ifdef BIN2BCD_FAST_EN
          next_state = SHIFT;
`else
          next_state = ADJUST;
`endif
        end
      end
      ADJUST: next_state = SHIFT;
      SHIFT: begin
        if (cnt == CW'(1)) begin
          next_state = DONE;
        end else begin
`ifdef BIN2BCD_FAST_EN
          next_state = SHIFT;
`else
          next_state = ADJUST;
`endif
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath: load on accept, correct/shift per iteration, publish on DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bin_sr  <= '0;
      bcd_sr  <= '0;
      cnt     <= '0;
      bcd_out <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bin_sr <= bin_in;
            bcd_sr <= '0;
            cnt    <= CW'(WIDTH);
          end
        end
        ADJUST: begin
          bcd_sr <= bcd_adj;
        end
        SHIFT: begin
          {bcd_sr, bin_sr} <= shifted;
          cnt              <= cnt - CW'(1);
        end
        DONE: begin
          bcd_out <= bcd_sr;
          done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Testbench for bin2bcd_seq: directed and randomized conversions checked
// against a decimal-arithmetic reference model with a cycle-level handshake
// model (acceptance, busy window, done pulse, held result).

module tb_bin2bcd_seq;

  localparam int WIDTH  = 8;
  localparam int DIGITS = 3;
  localparam int BW     = 4 * DIGITS;
`ifdef BIN2BCD_FAST_EN
  localparam int LAT = WIDTH + 1;
`else
  localparam int LAT = 2 * WIDTH + 1;
`endif

  logic              clk;
  logic              reset;
  logic              start;
  logic [WIDTH-1:0]  bin_in;
  logic              busy;
  logic              done;
  logic [BW-1:0]     bcd_out;

  int vectors;
  int miscompares;

  // Reference model state.
  int            edge_cnt;
  int            next_accept;
  int            acc_edge;
  int            done_edge;
  logic [BW-1:0] pend_val;
  logic [BW-1:0] held_out;
  int            accept_count;
  int            dut_done_count;
  int            last_done_edge;

  bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [BW-1:0] to_bcd(input int v);
    logic [BW-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int d = 0; d < DIGITS; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] rand_bin();
    return WIDTH'($urandom);
  endfunction

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic model_clear();
    acc_edge    = -1;
    done_edge   = -1;
    held_out    = '0;
    next_accept = 0;
  endtask

  // One clock: drive inputs, advance the model on the edge, check outputs.
  task automatic apply_stimulus(input logic s, input logic [WIDTH-1:0] b);
    logic exp_done;
    logic exp_busy;
    start  = s;
    bin_in = b;
    @(posedge clk);
    edge_cnt++;
    exp_done = (edge_cnt == done_edge);
    if (exp_done) held_out = pend_val;
    if (s && edge_cnt >= next_accept) begin
      acc_edge    = edge_cnt;
      done_edge   = edge_cnt + LAT;
      pend_val    = to_bcd(int'(b));
      next_accept = done_edge + 1;
      accept_count++;
    end
    exp_busy = (acc_edge >= 0) && (edge_cnt >= acc_edge) && (edge_cnt < done_edge);
    #1;
    if (done === 1'b1) begin
      dut_done_count++;
      last_done_edge = edge_cnt;
    end
    check_output("done", 32'(done), 32'(exp_done));
    check_output("busy", 32'(busy), 32'(exp_busy));
    check_output("bcd_out", 32'(bcd_out), 32'(held_out));
  endtask

  // Start one conversion and clock until the DUT reports done (bounded).
  task automatic convert(input logic [WIDTH-1:0] v);
    int acc;
    apply_stimulus(1'b1, v);
    acc = edge_cnt;
    last_done_edge = -1;
    for (int i = 0; i < LAT + 4; i++) begin
      apply_stimulus(1'b0, rand_bin());
      if (done === 1'b1) break;
    end
    check_output("latency", 32'(last_done_edge - acc), 32'(LAT));
  endtask

  initial begin
    int first_done;
    logic [WIDTH-1:0] dir_vals [4];
    vectors        = 0;
    miscompares    = 0;
    edge_cnt       = 0;
    accept_count   = 0;
    dut_done_count = 0;
    last_done_edge = -1;
    pend_val       = '0;
    model_clear();

    // Power-on reset.
    reset  = 1'b0;
    start  = 1'b0;
    bin_in = '0;
    #1;
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_done", 32'(done), 32'd0);
    check_output("rst_bcd", 32'(bcd_out), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Directed boundary values.
    dir_vals = '{8'd0, 8'd255, 8'd99, 8'd128};
    foreach (dir_vals[i]) convert(dir_vals[i]);

    // Start held high with a changing operand: only IDLE edges accept.
    accept_count   = 0;
    dut_done_count = 0;
    for (int i = 0; i < 40; i++) apply_stimulus(1'b1, rand_bin());
    for (int i = 0; i < LAT + 2; i++) apply_stimulus(1'b0, rand_bin());
    check_output("done_count", 32'(dut_done_count), 32'(accept_count));

    // Asynchronous reset in the middle of a conversion of 200.
    apply_stimulus(1'b1, 8'd200);
    for (int i = 0; i < 6; i++) apply_stimulus(1'b0, rand_bin());
    #2;
    reset = 1'b0;
    #1;
    check_output("midrst_busy", 32'(busy), 32'd0);
    check_output("midrst_done", 32'(done), 32'd0);
    check_output("midrst_bcd", 32'(bcd_out), 32'd0);
    model_clear();
    @(negedge clk);
    reset = 1'b1;
    convert(8'd42);

    // Back-to-back: new start in the done cycle of the previous conversion.
    convert(8'd250);
    first_done = last_done_edge;
    convert(8'd7);
    check_output("b2b_gap", 32'(last_done_edge - first_done), 32'(LAT + 1));

    // Exhaustive sweep of all operands.
    for (int v = 0; v < (1 << WIDTH); v++) convert(WIDTH'(v));

    $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
